pipelined_carry_increment_adder: RTL and testbench

Parametrised, pipelined carry-increment adder. It splits a WIDTH-bit operation into NUM_BLOCKS = WIDTH/BLOCK carry-lookahead blocks, with one register stage per block, and supports add, increment, subtract and decrement modes. A valid/ready handshake on both sides supports backpressure. It is the wide-datapath successor to the fixed 4-bit two-block incrementer and feeds arithmetic units that need throughput over latency.

---
 rtl/pipelined_carry_increment_adder.sv | 167 ++++++++++++++++
 tb/tb_pipelined_carry_increment_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_increment_adder.sv
// Pipelined carry-increment adder: WIDTH/BLOCK CLA blocks, one register stage per block,
// add/increment/subtract/decrement modes, valid/ready on both sides. Optional out_ovf via ADDER_OVF_EN.
module pipelined_carry_increment_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero
`ifdef ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NB = WIDTH / BLOCK;

  if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of BLOCK");
  end

  logic             en;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic             cin_c;

  // One BLOCK-wide lookahead slice: returns {carry_out, sum}.
  function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] a,
                                         input logic [BLOCK-1:0] b,
                                         input logic             c0);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  always_comb begin
    a_c   = in_a;
    b_c   = in_b;
    cin_c = in_cin;
    case (in_mode)
      2'b00: begin b_c = in_b;            cin_c = in_cin; end
      2'b01: begin b_c = {WIDTH{1'b0}};   cin_c = 1'b1;   end
      2'b10: begin b_c = ~in_b;           cin_c = 1'b1;   end
      2'b11: begin b_c = {WIDTH{1'b1}};   cin_c = 1'b0;   end
      default: begin b_c = in_b;          cin_c = in_cin; end
    endcase
  end

  // Whole pipeline moves together; a stalled output freezes every stage, bubbles included.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NB; k++) begin : stg
    logic [BLOCK-1:0]         blk_a;
    logic [BLOCK-1:0]         blk_b;
    logic                     blk_c;
    logic                     vld_in;
    logic [BLOCK:0]           res;
    logic [(k+1)*BLOCK-1:0]   sum_in;
    logic                     vld;
    logic [(k+1)*BLOCK-1:0]   sum;
    logic                     cy;

    if (k == 0) begin : g_src
      assign blk_a  = a_c[BLOCK-1:0];
      assign blk_b  = b_c[BLOCK-1:0];
      assign blk_c  = cin_c;
      assign vld_in = in_valid;
      assign sum_in = res[BLOCK-1:0];
    end else begin : g_src
      assign blk_a  = stg[k-1].g_hi.a_hi[BLOCK-1:0];
      assign blk_b  = stg[k-1].g_hi.b_hi[BLOCK-1:0];
      assign blk_c  = stg[k-1].cy;
      assign vld_in = stg[k-1].vld;
      assign sum_in = {res[BLOCK-1:0], stg[k-1].sum};
    end

    assign res = cla(blk_a, blk_b, blk_c);

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        sum <= '0;
        cy  <= 1'b0;
      end else if (en) begin
        vld <= vld_in;
        sum <= sum_in;
        cy  <= res[BLOCK];
      end
    end

    // Operand bits not yet consumed ride down the delay chain.
    if (k < NB - 1) begin : g_hi
      localparam int HW = WIDTH - (k + 1) * BLOCK;
      logic [HW-1:0] a_nx;
      logic [HW-1:0] b_nx;
      logic [HW-1:0] a_hi;
      logic [HW-1:0] b_hi;

      if (k == 0) begin : g_in
        assign a_nx = a_c[WIDTH-1:BLOCK];
        assign b_nx = b_c[WIDTH-1:BLOCK];
      end else begin : g_in
        assign a_nx = stg[k-1].g_hi.a_hi[HW+BLOCK-1:BLOCK];
        assign b_nx = stg[k-1].g_hi.b_hi[HW+BLOCK-1:BLOCK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (en) begin
          a_hi <= a_nx;
          b_hi <= b_nx;
        end
      end
    end

    if (k == NB - 1) begin : g_last
      logic zero;
`ifdef ADDER_OVF_EN
      logic ovf;
`endif
      // Flags registered with the final sum so they stay aligned with it.
      always_ff @(posedge clk) begin
        if (rst) begin
          zero <= 1'b0;
`ifdef ADDER_OVF_EN
          ovf  <= 1'b0;
`endif
        end else if (en) begin
          zero <= (sum_in == '0);
`ifdef ADDER_OVF_EN
          // Carry into MSB recovered as a^b^s at the MSB.
          ovf  <= blk_a[BLOCK-1] ^ blk_b[BLOCK-1] ^ res[BLOCK-1] ^ res[BLOCK];
`endif
        end
      end
    end
  end

  assign out_valid = stg[NB-1].vld;
  assign out_sum   = stg[NB-1].sum;
  assign out_cout  = stg[NB-1].cy;
  assign out_zero  = stg[NB-1].g_last.zero;
`ifdef ADDER_OVF_EN
  assign out_ovf   = stg[NB-1].g_last.ovf;
`endif

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Scoreboard bench for pipelined_carry_increment_adder (WIDTH=16, BLOCK=4).
// Directed vectors push hand-computed results; a negedge monitor pops on each output handshake.
module tb_pipelined_carry_increment_adder;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_INC = 2'b01;
  localparam logic [1:0] M_SUB = 2'b10;
  localparam logic [1:0] M_DEC = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_zero;
`ifdef ADDER_OVF_EN
  logic        out_ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  pipelined_carry_increment_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero)
`ifdef ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each transferred result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %04h expected none", out_sum);
      end else begin
        mon_e = sb.pop_front();
        check("sum", {16'd0, out_sum}, {16'd0, mon_e.sum});
        check("cout", {31'd0, out_cout}, {31'd0, mon_e.cout});
        check("zero", {31'd0, out_zero}, {31'd0, mon_e.zero});
`ifdef ADDER_OVF_EN
        check("ovf", {31'd0, out_ovf}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  task automatic send(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_mode  = mode;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      e.sum  = es;
      e.cout = ec;
      e.zero = (es == 16'h0000);
      e.ovf  = eo;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    check(name, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name);
    int lat;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if (out_valid) lat = n;
    end
    check(name, lat, 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_cin    = 1'b0;
    in_mode   = M_ADD;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: add with latency
    send(M_ADD, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    check_latency("t1_latency");
    wait_drain("t1_drain");

    // Add variants, increment/decrement wrap, subtract, issued back-to-back
    send(M_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
    send(M_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(M_INC, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(M_DEC, 16'h0000, 16'h5555, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send(M_DEC, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(M_INC, 16'h00FF, 16'hFFFF, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(M_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    send(M_SUB, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    send(M_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Overflow boundaries
    send(M_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(M_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(M_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_drain("t23_drain");

    // 4: backpressure, 8 back-to-back adds i+i
    fork
      begin : stim
        for (int i = 1; i <= 8; i++) begin
          send(M_ADD, 16'(i), 16'(i), 1'b0, 16'(2 * i), 1'b0, 1'b0);
        end
      end
      begin : ready_ctl
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        check("t4_first_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("t4_hold_sum", {16'd0, out_sum}, 32'd4);
          check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
          check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // 5: reset with four operations in flight
    out_ready = 1'b0;
    send(M_ADD, 16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0);
    send(M_ADD, 16'h2222, 16'h1111, 1'b0, 16'h3333, 1'b0, 1'b0);
    send(M_INC, 16'h0041, 16'h0000, 1'b0, 16'h0042, 1'b0, 1'b0);
    send(M_SUB, 16'h0009, 16'h0003, 1'b0, 16'h0006, 1'b1, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_sum", {16'd0, out_sum}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("t5_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(M_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    check_latency("t5_latency");
    wait_drain("t5_drain");

    repeat (4) @(negedge clk);
    check("final_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
